// File: rtl/seg7_capture.sv
// seg7_capture: recovers settled BCD digits from a multiplexed active-low 7-segment bus.
// Each one-hot dwell yields a single sample, and a digit commits after STABLE identical samples.
module seg7_capture #(
  parameter int NDIG   = 4,
  parameter int SETTLE = 2,
  parameter int STABLE = 3,
  localparam int IW    = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [6:0]        i_seg7,
  input  logic [NDIG-1:0]   i_dig_sel,
  output logic [4*NDIG-1:0] o_dout,
  output logic [NDIG-1:0]   o_valid,
  output logic [NDIG-1:0]   o_err,
  output logic              o_upd,
  output logic [IW-1:0]     o_upd_idx
);
  localparam logic [4:0] LSAMP = 5'(SETTLE);
  localparam logic [4:0] LMAX  = 5'(SETTLE + 1);
  localparam logic [2:0] ST    = 3'(STABLE);
  logic [NDIG-1:0] r_sel;
  logic [4:0]      r_len;
  logic [6:0]      r_cand [NDIG];
  logic [2:0]      r_mcnt [NDIG];
  logic            w_onehot, w_same, w_sample, w_match, w_commit;
  logic            w_is_dec, w_is_blank;
  logic [3:0]      w_dec;
  logic [2:0]      w_cnt, w_ncnt;
  logic [IW-1:0]   w_idx;
  assign w_onehot = $onehot(i_dig_sel);
  assign w_same   = w_onehot && (i_dig_sel == r_sel);
  // the dwell reaches SETTLE+1 cycles exactly when the stored length equals SETTLE
  assign w_sample = w_same && (r_len == LSAMP);
  assign w_cnt    = r_mcnt[w_idx];
  assign w_match  = (i_seg7 == r_cand[w_idx]);
  assign w_ncnt   = w_match ? ((w_cnt == ST) ? ST : w_cnt + 3'd1) : 3'd1;
  assign w_commit = w_sample && (w_ncnt == ST) && !(w_match && (w_cnt == ST));
  always_comb begin
    w_idx = '0;
    for (int k = 0; k < NDIG; k++)
      if (i_dig_sel[k]) w_idx = IW'(k);
  end
  always_comb begin
    w_dec      = 4'd0;
    w_is_dec   = 1'b1;
    w_is_blank = 1'b0;
    case (i_seg7)
      7'b1000000: w_dec = 4'd0;
      7'b1111001: w_dec = 4'd1;
      7'b0100100: w_dec = 4'd2;
      7'b0110000: w_dec = 4'd3;
      7'b0011001: w_dec = 4'd4;
      7'b0010010: w_dec = 4'd5;
      7'b0000010: w_dec = 4'd6;
      7'b1111000: w_dec = 4'd7;
      7'b0000000: w_dec = 4'd8;
      7'b0010000: w_dec = 4'd9;
      7'b1111111: begin
        w_is_dec   = 1'b0;
        w_is_blank = 1'b1;
      end
      default: w_is_dec = 1'b0;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sel <= '0;
      r_len <= '0;
    end else begin
      r_sel <= i_dig_sel;
      r_len <= !w_onehot ? 5'd0 : !w_same ? 5'd1 : (r_len == LMAX) ? r_len : r_len + 5'd1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < NDIG; k++) begin
        r_cand[k] <= 7'h7f;
        r_mcnt[k] <= 3'd0;
      end
      o_dout    <= '0;
      o_valid   <= '0;
      o_err     <= '0;
      o_upd     <= 1'b0;
      o_upd_idx <= '0;
    end else begin
      o_upd <= w_commit;
      if (w_sample) begin
        r_cand[w_idx] <= i_seg7;
        r_mcnt[w_idx] <= w_ncnt;
      end
      if (w_commit) begin
        o_upd_idx      <= w_idx;
        o_valid[w_idx] <= w_is_dec;
        o_err[w_idx]   <= !w_is_dec && !w_is_blank;
        if (w_is_dec) o_dout[4*w_idx +: 4] <= w_dec;
      end
    end
  end
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed vectors with hand-computed expectations for seg7_capture.
module tb_seg7_capture;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = 7'h7f;
  logic [3:0]  sel = 4'b0000;
  logic [15:0] dout;
  logic [3:0]  valid, err;
  logic        upd;
  logic [1:0]  upd_idx;
  int          n_checks = 0;
  int          n_fail = 0;
  int          upd_cnt = 0;
  int          base;
  logic [1:0]  idx_q [$];
  logic [6:0]  pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  seg7_capture #(.NDIG(4), .SETTLE(2), .STABLE(3)) dut (
    .i_clk(clk), .i_reset(rst), .i_seg7(seg), .i_dig_sel(sel),
    .o_dout(dout), .o_valid(valid), .o_err(err), .o_upd(upd), .o_upd_idx(upd_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (upd) begin
      upd_cnt++;
      idx_q.push_back(upd_idx);
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan(input int d, input logic [6:0] p, input int n);
    sel = 4'(1 << d);
    seg = p;
    cycles(n);
    sel = 4'b0000;
    seg = 7'h7f;
    cycles(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    cycles(3);
    check("rst_dout", dout, 0);
    check("rst_valid", valid, 0);
    check("rst_err", err, 0);
    check("rst_upd", upd, 0);
    check("rst_idx", upd_idx, 0);
    rst = 1'b0;
    // basic capture: 1,2,3,4 on digits 0..3
    for (int s = 0; s < 3; s++) begin
      if (s == 2) check("basic_early_valid", valid, 4'h0);
      for (int d = 0; d < 4; d++) scan(d, pat[d+1], 4);
    end
    check("basic_dout", dout, 16'h4321);
    check("basic_valid", valid, 4'hf);
    check("basic_err", err, 4'h0);
    check("basic_upd_cnt", upd_cnt, 4);
    check("basic_qsize", idx_q.size(), 4);
    for (int i = 0; i < 4; i++) check("basic_upd_idx", (i < idx_q.size()) ? idx_q[i] : 2'bxx, i);
    // short dwells never sample
    do_reset();
    base = upd_cnt;
    for (int s = 0; s < 3; s++)
      for (int d = 0; d < 4; d++) scan(d, pat[d+1], 2);
    check("short_dout", dout, 0);
    check("short_valid", valid, 0);
    check("short_upd", upd_cnt - base, 0);
    // long dwell counts once
    scan(0, pat[5], 10);
    scan(0, pat[5], 10);
    check("long_valid_2", valid[0], 0);
    check("long_upd_2", upd_cnt - base, 0);
    scan(0, pat[5], 10);
    check("long_valid_3", valid[0], 1);
    check("long_dout_3", dout, 16'h0005);
    check("long_upd_3", upd_cnt - base, 1);
    // glitch rejection on digit 1
    base = upd_cnt;
    for (int s = 0; s < 3; s++) scan(1, pat[7], 4);
    check("gl_dout", dout, 16'h0075);
    check("gl_upd", upd_cnt - base, 1);
    base = upd_cnt;
    scan(1, 7'h7f, 4);
    check("gl_blank_dout", dout[7:4], 7);
    check("gl_blank_valid", valid[1], 1);
    check("gl_blank_upd", upd_cnt - base, 0);
    scan(1, pat[7], 4);
    scan(1, pat[7], 4);
    check("gl_two_upd", upd_cnt - base, 0);
    scan(1, pat[7], 4);
    check("gl_three_upd", upd_cnt - base, 1);
    check("gl_three_idx", upd_idx, 1);
    scan(1, pat[7], 4);
    check("gl_sat_upd", upd_cnt - base, 1);
    // illegal then blank on digit 2
    for (int s = 0; s < 3; s++) scan(2, pat[3], 4);
    check("il_pre_dout", dout[11:8], 3);
    check("il_pre_valid", valid[2], 1);
    for (int s = 0; s < 3; s++) scan(2, 7'h2a, 4);
    check("il_err", err[2], 1);
    check("il_valid", valid[2], 0);
    check("il_dout", dout[11:8], 3);
    base = upd_cnt;
    for (int s = 0; s < 3; s++) scan(2, 7'h7f, 4);
    check("bl_err", err[2], 0);
    check("bl_valid", valid[2], 0);
    check("bl_dout", dout[11:8], 3);
    check("bl_upd", upd_cnt - base, 1);
    // non-one-hot selects never sample
    base = upd_cnt;
    seg = pat[0];
    sel = 4'b0000;
    cycles(20);
    sel = 4'b0110;
    cycles(20);
    sel = 4'b0000;
    cycles(1);
    check("nh_upd", upd_cnt - base, 0);
    check("nh_dout", dout, 16'h0375);
    check("nh_valid", valid, 4'b0011);
    check("nh_err", err, 4'b0000);
    // reset in the middle of a dwell after two matching samples
    scan(3, pat[9], 4);
    scan(3, pat[9], 4);
    sel = 4'b1000;
    seg = pat[9];
    cycles(1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("mr_dout", dout, 0);
    check("mr_valid", valid, 0);
    check("mr_upd", upd, 0);
    base = upd_cnt;
    cycles(4);
    sel = 4'b0000;
    cycles(1);
    scan(3, pat[9], 4);
    check("mr_two_valid", valid[3], 0);
    check("mr_two_upd", upd_cnt - base, 0);
    scan(3, pat[9], 4);
    check("mr_three_valid", valid[3], 1);
    check("mr_three_dout", dout, 16'h9000);
    check("mr_three_upd", upd_cnt - base, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
